uart_pkt_parser: RTL and testbench

//  Downstream consumer of the UART rx FIFO: pops received bytes, finds framed packets
//  (SOF, LEN, payload, checksum), buffers the payload and releases it on a valid/ready

---
 rtl/uart_pkt_parser_pkg.sv | 22 ++
 rtl/uart_pkt_parser_if.sv | 25 ++
 rtl/uart_pkt_parser_buf.sv | 25 ++
 rtl/uart_pkt_parser.sv | 177 +++++++++++++++++
 tb/tb_uart_pkt_parser.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkt_parser_pkg.sv
// Shared types for the UART packet parser: FSM states, error codes and the
// default start-of-frame marker.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CSUM,
    SEND
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_CSUM = 2'b01,
    ERR_LEN  = 2'b10,
    ERR_TO   = 2'b11
  } err_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_pkt_parser_if.sv
// Bundles the rx FIFO pop side and the payload stream side of the parser.
// master = parser view, slave = FIFO/sink view.
interface uart_pkt_parser_if #(
  parameter int DATA_BITS = 8
);

  logic                 rx_empty;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_uart;
  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;

  modport master (
    input  rx_empty, rd_data, m_ready,
    output rd_uart, m_data, m_valid, m_last
  );

  modport slave (
    output rx_empty, rd_data, m_ready,
    input  rd_uart, m_data, m_valid, m_last
  );

endinterface

// File: rtl/uart_pkt_parser_buf.sv
// Payload buffer: MAX_LEN x DATA_BITS register array, one synchronous write
// port and one asynchronous read port. Contents are not reset.
module uart_pkt_buf #(
  parameter int DATA_BITS = 8,
  parameter int MAX_LEN   = 16,
  parameter int AW        = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [MAX_LEN];

  // Store one payload byte per accepted pop.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_pkt_parser.sv
// UART packet parser: pops the rx FIFO, frames SOF/LEN/payload/checksum,
// buffers the payload and streams it out only once the checksum is good.
//
//  state   | meaning
//  IDLE    | hunting for SOF, non-SOF bytes discarded
//  LEN     | next byte is payload length
//  PAYLOAD | storing payload bytes into the buffer
//  CSUM    | next byte closes the running sum to zero
//  SEND    | streaming buffered payload, FIFO not popped
module uart_pkt_parser
  import uart_pkt_pkg::*;
#(
  parameter int                   DATA_BITS = 8,
  parameter int                   MAX_LEN   = 16,
  parameter logic [DATA_BITS-1:0] SOF_BYTE  = DATA_BITS'(SOF_DEFAULT),
  parameter int                   TO_WIDTH  = 16
) (
  input  logic                clk,
  input  logic                reset,
  uart_pkt_parser_if.master   bus,
  input  logic [TO_WIDTH-1:0] timeout_cycles,
  output logic                frame_ok,
  output logic                frame_err,
  output logic [1:0]          err_code,
  output logic                busy
);

  localparam int PW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [DATA_BITS-1:0] MAX_LEN_W = DATA_BITS'(MAX_LEN);

  state_t               state, state_n;
  logic [DATA_BITS-1:0] len, len_n;
  logic [DATA_BITS-1:0] sum, sum_n;
  logic [PW-1:0]        wr_ptr, wr_ptr_n;
  logic [PW-1:0]        rd_ptr, rd_ptr_n;
  logic [TO_WIDTH-1:0]  idle_cnt, idle_cnt_n;
  err_t                 err, err_n;
  logic                 ok_n, ferr_n;

  logic                 in_frame, pop, hs, to_hit, buf_we, last_byte;
  logic [PW-1:0]        wr_ptr_inc, rd_ptr_inc;
  logic [DATA_BITS-1:0] sum_csum, buf_rdata;

  assign in_frame   = state inside {LEN, PAYLOAD, CSUM};
  // Gated by reset so the FIFO is never popped while the parser is held.
  assign pop        = ~reset & ~bus.rx_empty & ((state == IDLE) | in_frame);
  assign wr_ptr_inc = wr_ptr + PW'(1);
  assign rd_ptr_inc = rd_ptr + PW'(1);
  assign last_byte  = (DATA_BITS'(rd_ptr_inc) == len);
  assign sum_csum   = sum + bus.rd_data;
  assign to_hit     = (timeout_cycles != '0) && (idle_cnt == timeout_cycles);
  assign hs         = bus.m_valid & bus.m_ready;

  assign bus.rd_uart = pop;
  assign bus.m_valid = (state == SEND);
  assign bus.m_data  = (state == SEND) ? buf_rdata : '0;
  assign bus.m_last  = (state == SEND) & last_byte;
  assign busy        = (state != IDLE);
  assign err_code    = err;

  uart_pkt_buf #(
    .DATA_BITS(DATA_BITS),
    .MAX_LEN  (MAX_LEN),
    .AW       (AW)
  ) u_buf (
    .clk  (clk),
    .we   (buf_we),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(bus.rd_data),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(buf_rdata)
  );

  // State and datapath registers; a reset aborts any frame without pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      len       <= '0;
      sum       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      idle_cnt  <= '0;
      err       <= ERR_NONE;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      len       <= len_n;
      sum       <= sum_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      idle_cnt  <= idle_cnt_n;
      err       <= err_n;
      frame_ok  <= ok_n;
      frame_err <= ferr_n;
    end
  end

  // Next-state, framing checks, buffer writes and the inter-byte timeout.
  always_comb begin
    state_n    = state;
    len_n      = len;
    sum_n      = sum;
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    err_n      = err;
    ok_n       = 1'b0;
    ferr_n     = 1'b0;
    buf_we     = 1'b0;
    idle_cnt_n = '0;

    // Saturating idle count, only while waiting on bytes mid-frame.
    if (in_frame && !pop) begin
      idle_cnt_n = (idle_cnt == '1) ? idle_cnt : idle_cnt + TO_WIDTH'(1);
    end

    case (state)
      IDLE: begin
        if (pop && (bus.rd_data == SOF_BYTE)) state_n = LEN;
      end
      LEN: begin
        if (pop) begin
          len_n = bus.rd_data;
          if ((bus.rd_data == '0) || (bus.rd_data > MAX_LEN_W)) begin
            ferr_n  = 1'b1;
            err_n   = ERR_LEN;
            state_n = IDLE;
          end else begin
            sum_n    = bus.rd_data;
            wr_ptr_n = '0;
            state_n  = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (pop) begin
          buf_we   = 1'b1;
          sum_n    = sum_csum;
          wr_ptr_n = wr_ptr_inc;
          if (DATA_BITS'(wr_ptr_inc) == len) state_n = CSUM;
        end
      end
      CSUM: begin
        if (pop) begin
          if (sum_csum == '0) begin
            rd_ptr_n = '0;
            state_n  = SEND;
          end else begin
            ferr_n  = 1'b1;
            err_n   = ERR_CSUM;
            state_n = IDLE;
          end
        end
      end
      SEND: begin
        if (hs) begin
          if (last_byte) begin
            ok_n    = 1'b1;
            state_n = IDLE;
          end else begin
            rd_ptr_n = rd_ptr_inc;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A byte arriving in the same cycle wins over the timeout.
    if (in_frame && !pop && to_hit) begin
      ferr_n  = 1'b1;
      err_n   = ERR_TO;
      state_n = IDLE;
    end
  end

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Self-checking bench for uart_pkt_parser: directed frames from the block's
// test list followed by randomized frames, checked against a frame-level
// scoreboard of expected payload bytes and expected ok/error events.
module tb_uart_pkt_parser;

  localparam int DB = 8;
  localparam int ML = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] timeout_cycles = 16'd0;
  logic        frame_ok, frame_err, busy;
  logic [1:0]  err_code;

  uart_pkt_parser_if #(.DATA_BITS(DB)) bus ();

  uart_pkt_parser #(
    .DATA_BITS(DB),
    .MAX_LEN  (ML),
    .SOF_BYTE (8'hA5),
    .TO_WIDTH (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .timeout_cycles(timeout_cycles),
    .frame_ok      (frame_ok),
    .frame_err     (frame_err),
    .err_code      (err_code),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo[$];
  exp_t       exp_bytes[$];
  int         exp_evt[$];
  int         vectors = 0;
  int         miscompares = 0;
  bit         stall_en = 1'b0;
  bit         ready_rand = 1'b0;
  int         pop_run = 0, pop_max = 0, pop_total = 0;
  int         ok_seen = 0, err_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    bit st;
    st = stall_en && ($urandom_range(0, 3) == 0);
    bus.rx_empty = (fifo.size() == 0) || st;
    bus.rd_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    if (ready_rand) bus.m_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic push_raw(input bq_t b);
    foreach (b[i]) fifo.push_back(b[i]);
    drive_fifo();
  endtask

  // One clock: sample at the edge, then 1 time unit later retire pops,
  // score handshakes and pulses, and present the next FIFO head.
  task automatic tick();
    logic       hs, pop, ml;
    logic [7:0] md;
    int         code;
    exp_t       e;
    @(posedge clk);
    hs  = bus.m_valid & bus.m_ready;
    pop = bus.rd_uart;
    md  = bus.m_data;
    ml  = bus.m_last;
    #1;
    if (pop && fifo.size() != 0) fifo.delete(0);
    if (pop) begin
      pop_total++;
      pop_run++;
      if (pop_run > pop_max) pop_max = pop_run;
    end else begin
      pop_run = 0;
    end
    if (hs) begin
      chk("byte_expected", exp_bytes.size() != 0, 1);
      if (exp_bytes.size() != 0) begin
        e = exp_bytes.pop_front();
        chk("m_data", md, e.d);
        chk("m_last", ml, e.l);
      end
    end
    if (frame_ok || frame_err) begin
      if (frame_ok) ok_seen++;
      if (frame_err) err_seen++;
      chk("ok_err_exclusive", frame_ok & frame_err, 0);
      chk("pulse_at_idle", busy, 0);
      code = frame_ok ? 0 : int'(err_code);
      chk("event_expected", exp_evt.size() != 0, 1);
      if (exp_evt.size() != 0) chk("event_code", code, exp_evt.pop_front());
    end
    drive_fifo();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((fifo.size() != 0 || exp_bytes.size() != 0 || exp_evt.size() != 0 || busy)
           && n < budget) begin
      tick();
      n++;
    end
    chk(tag, n < budget, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stream"}, {bus.rd_uart, bus.m_valid, bus.m_data, bus.m_last}, 0);
    chk({tag, "_status"}, {frame_ok, frame_err, err_code, busy}, 0);
  endtask

  // Random frame: SOF, LEN, payload, checksum (+delta to corrupt).
  task automatic queue_frame(input logic [7:0] len_b, input logic [7:0] delta);
    logic [7:0] s, b;
    fifo.push_back(8'hA5);
    fifo.push_back(len_b);
    if (len_b == 8'd0 || int'(len_b) > ML) begin
      exp_evt.push_back(2);
      return;
    end
    s = len_b;
    for (int i = 0; i < int'(len_b); i++) begin
      b = 8'($urandom);
      fifo.push_back(b);
      s = s + b;
      if (delta == 8'd0) exp_bytes.push_back({b, (i == int'(len_b) - 1)});
    end
    b = 8'h00 - s + delta;
    fifo.push_back(b);
    exp_evt.push_back((delta == 8'd0) ? 0 : 1);
  endtask

  initial begin
    int         n, base, fsz, k, ng;
    logic [7:0] d0, g, lb;

    bus.rx_empty = 1'b1;
    bus.rd_data  = 8'h00;
    bus.m_ready  = 1'b1;
    reset        = 1'b1;
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();

    // Good frame, full-rate pops.
    pop_run = 0; pop_max = 0; pop_total = 0;
    exp_bytes.push_back({8'h11, 1'b0});
    exp_bytes.push_back({8'h22, 1'b0});
    exp_bytes.push_back({8'h33, 1'b1});
    exp_evt.push_back(0);
    push_raw('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97});
    drain("good_drain", 200);
    chk("good_pop_total", pop_total, 6);
    chk("good_pop_run", pop_max, 6);
    chk("good_ok_count", ok_seen, 1);

    // Bad checksum.
    exp_evt.push_back(1);
    push_raw('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00});
    drain("csum_drain", 200);
    chk("csum_err_code", err_code, 1);

    // Leading garbage, then a one-byte frame; err_code held through ok.
    exp_bytes.push_back({8'h7F, 1'b1});
    exp_evt.push_back(0);
    push_raw('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7F, 8'h80});
    drain("garbage_drain", 200);
    chk("garbage_err_held", err_code, 1);

    // Bad LEN both ends, then a good frame carrying an SOF value as data.
    exp_evt.push_back(2);
    exp_evt.push_back(2);
    exp_bytes.push_back({8'hA5, 1'b0});
    exp_bytes.push_back({8'h5A, 1'b1});
    exp_evt.push_back(0);
    push_raw('{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h02, 8'hA5, 8'h5A, 8'hFF});
    drain("len_drain", 200);
    chk("len_err_code", err_code, 2);

    // Timeout enabled: stall mid-payload.
    timeout_cycles = 16'd50;
    exp_evt.push_back(3);
    push_raw('{8'hA5, 8'h04, 8'h01});
    repeat (60) tick();
    chk("to_event_seen", exp_evt.size(), 0);
    chk("to_err_code", err_code, 3);
    chk("to_idle", busy, 0);

    // Timeout disabled: the same stall waits, then the frame completes.
    timeout_cycles = 16'd0;
    base = err_seen;
    push_raw('{8'hA5, 8'h04, 8'h01});
    repeat (60) tick();
    chk("to0_still_busy", busy, 1);
    chk("to0_no_err", err_seen - base, 0);
    exp_bytes.push_back({8'h01, 1'b0});
    exp_bytes.push_back({8'h02, 1'b0});
    exp_bytes.push_back({8'h03, 1'b0});
    exp_bytes.push_back({8'h04, 1'b1});
    exp_evt.push_back(0);
    push_raw('{8'h02, 8'h03, 8'h04, 8'hF2});
    drain("to0_drain", 200);

    // Backpressure mid-SEND with the next frame waiting in the FIFO.
    bus.m_ready = 1'b0;
    exp_bytes.push_back({8'h5A, 1'b0});
    exp_bytes.push_back({8'hC3, 1'b1});
    exp_evt.push_back(0);
    exp_bytes.push_back({8'h42, 1'b1});
    exp_evt.push_back(0);
    push_raw('{8'hA5, 8'h02, 8'h5A, 8'hC3, 8'hE1, 8'hA5, 8'h01, 8'h42, 8'hBD});
    n = 0;
    while (!bus.m_valid && n < 50) begin
      tick();
      n++;
    end
    chk("bp_reach_send", bus.m_valid, 1);
    chk("bp_first_data", bus.m_data, 8'h5A);
    d0  = bus.m_data;
    fsz = fifo.size();
    chk("bp_fifo_level", fsz, 4);
    repeat (10) begin
      tick();
      chk("bp_hold_data", bus.m_data, d0);
      chk("bp_hold_valid", bus.m_valid, 1);
      chk("bp_no_pop", bus.rd_uart, 0);
    end
    chk("bp_fifo_untouched", fifo.size(), fsz);
    bus.m_ready = 1'b1;
    drain("bp_drain", 200);

    // Reset while in PAYLOAD: immediate abort, no pulses afterwards.
    base = ok_seen + err_seen;
    push_raw('{8'hA5, 8'h08, 8'h01, 8'h02, 8'h03});
    repeat (8) tick();
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk_zero("mid_reset");
    fifo.delete();
    drive_fifo();
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("mid_no_pulse", ok_seen + err_seen - base, 0);
    chk("mid_idle", busy, 0);

    // Randomized frames with FIFO gaps and sink backpressure.
    stall_en   = 1'b1;
    ready_rand = 1'b1;
    for (int f = 0; f < 30; f++) begin
      k  = $urandom_range(0, 9);
      ng = $urandom_range(0, 2);
      for (int j = 0; j < ng; j++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h3C;
        fifo.push_back(g);
      end
      if (k < 6) begin
        queue_frame(8'($urandom_range(1, ML)), 8'h00);
      end else if (k < 8) begin
        queue_frame(8'($urandom_range(1, ML)), 8'($urandom_range(1, 255)));
      end else begin
        lb = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(ML + 1, 255));
        queue_frame(lb, 8'h00);
      end
    end
    drive_fifo();
    drain("rand_drain", 20000);
    stall_en    = 1'b0;
    ready_rand  = 1'b0;
    bus.m_ready = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
